// File: rtl/rx_decoder_8b10b_if.sv
// Symbol-side bus of the 8b/10b receive decoder: deserializer input and decoded
// byte/status output toward the RX elastic buffer.
interface rx_decoder_8b10b_if;
    logic [9:0] RxParallel_10;
    logic       RxValid_10;
    logic [7:0] RxParallel_8;
    logic       RxDataK;
    logic       RxValid_8;
    logic       DecodeError;
    logic       DisparityError;
    logic       CommaDetect;
    logic       Synced;

    modport master (
        output RxParallel_10, RxValid_10,
        input  RxParallel_8, RxDataK, RxValid_8, DecodeError, DisparityError,
               CommaDetect, Synced
    );

    modport slave (
        input  RxParallel_10, RxValid_10,
        output RxParallel_8, RxDataK, RxValid_8, DecodeError, DisparityError,
               CommaDetect, Synced
    );
endinterface

// File: rtl/rx_decoder_8b10b.sv
// 8b/10b receive decoder: symbol capture, table decode with running-disparity
// check, and a comma-driven LOS/ACQ/SYNC link-sync state machine.
module rx_decoder_8b10b #(
    parameter int SYNC_COMMAS = 3,
    parameter int ERR_LIMIT   = 4,
    parameter int GOOD_RUN    = 4
) (
    input logic BitCLK_10,
    input logic Reset,
    rx_decoder_8b10b_if.slave rx
);
    localparam int CW = $clog2(SYNC_COMMAS) + 1;
    localparam int EW = $clog2(ERR_LIMIT) + 1;
    localparam int GW = $clog2(GOOD_RUN) + 1;

    typedef enum logic [1:0] {ST_LOS, ST_ACQ, ST_SYNC} state_t;

    // 6b abcdei -> {valid, EDCBA}; K28 patterns decode as x = 28 here.
    function automatic logic [5:0] dec6(input logic [5:0] s);
        logic [4:0] x;
        logic       ok;
        ok = 1'b1;
        x  = 5'd0;
        case (s)
            6'b100111, 6'b011000: x = 5'd0;
            6'b011101, 6'b100010: x = 5'd1;
            6'b101101, 6'b010010: x = 5'd2;
            6'b110001:            x = 5'd3;
            6'b110101, 6'b001010: x = 5'd4;
            6'b101001:            x = 5'd5;
            6'b011001:            x = 5'd6;
            6'b111000, 6'b000111: x = 5'd7;
            6'b111001, 6'b000110: x = 5'd8;
            6'b100101:            x = 5'd9;
            6'b010101:            x = 5'd10;
            6'b110100:            x = 5'd11;
            6'b001101:            x = 5'd12;
            6'b101100:            x = 5'd13;
            6'b011100:            x = 5'd14;
            6'b010111, 6'b101000: x = 5'd15;
            6'b011011, 6'b100100: x = 5'd16;
            6'b100011:            x = 5'd17;
            6'b010011:            x = 5'd18;
            6'b110010:            x = 5'd19;
            6'b001011:            x = 5'd20;
            6'b101010:            x = 5'd21;
            6'b011010:            x = 5'd22;
            6'b111010, 6'b000101: x = 5'd23;
            6'b110011, 6'b001100: x = 5'd24;
            6'b100110:            x = 5'd25;
            6'b010110:            x = 5'd26;
            6'b110110, 6'b001001: x = 5'd27;
            6'b001110, 6'b001111, 6'b110000: x = 5'd28;
            6'b101110, 6'b010001: x = 5'd29;
            6'b011110, 6'b100001: x = 5'd30;
            6'b101011, 6'b010100: x = 5'd31;
            default:              ok = 1'b0;
        endcase
        return {ok, x};
    endfunction

    // Data 4b fghj -> {valid, alt7, HGF}.
    function automatic logic [4:0] dec4(input logic [3:0] f);
        logic [2:0] y;
        logic       ok;
        logic       alt;
        ok  = 1'b1;
        alt = 1'b0;
        y   = 3'd0;
        case (f)
            4'b1011, 4'b0100: y = 3'd0;
            4'b1001:          y = 3'd1;
            4'b0101:          y = 3'd2;
            4'b1100, 4'b0011: y = 3'd3;
            4'b1101, 4'b0010: y = 3'd4;
            4'b1010:          y = 3'd5;
            4'b0110:          y = 3'd6;
            4'b1110, 4'b0001: y = 3'd7;
            4'b0111, 4'b1000: begin y = 3'd7; alt = 1'b1; end
            default:          ok = 1'b0;
        endcase
        return {ok, alt, y};
    endfunction

    // K28 4b, normalised to the form that follows 110000.
    function automatic logic [3:0] deck28(input logic [3:0] f);
        logic [2:0] y;
        logic       ok;
        ok = 1'b1;
        y  = 3'd0;
        case (f)
            4'b1011: y = 3'd0;
            4'b0110: y = 3'd1;
            4'b1010: y = 3'd2;
            4'b1100: y = 3'd3;
            4'b1101: y = 3'd4;
            4'b0101: y = 3'd5;
            4'b1001: y = 3'd6;
            4'b0111: y = 3'd7;
            default: ok = 1'b0;
        endcase
        return {ok, y};
    endfunction

    logic [9:0] sym_reg;
    logic       sym_valid_reg;

    always_ff @(posedge BitCLK_10 or negedge Reset) begin
        if (!Reset) begin
            sym_reg       <= '0;
            sym_valid_reg <= 1'b0;
        end else begin
            sym_valid_reg <= rx.RxValid_10;
            if (rx.RxValid_10) sym_reg <= rx.RxParallel_10;
        end
    end

    logic [5:0] six;
    logic [3:0] four;
    logic [5:0] d6;
    logic [4:0] d4;
    logic [3:0] k4;
    logic       is_k28;
    logic       code_ok;
    logic       dec_k;
    logic [7:0] dec_byte;
    logic       comma;
    logic       pos6, neg6, pos4, neg4;
    logic       rd_reg, rd_mid, rd_next;
    logic       disp_err;

    assign six    = sym_reg[9:4];
    assign four   = sym_reg[3:0];
    assign d6     = dec6(six);
    assign d4     = dec4(four);
    assign is_k28 = (six == 6'b001111) || (six == 6'b110000);
    assign k4     = deck28((six == 6'b110000) ? four : ~four);

    always_comb begin
        code_ok  = 1'b0;
        dec_k    = 1'b0;
        dec_byte = {d4[2:0], d6[4:0]};
        comma    = 1'b0;
        if (is_k28) begin
            code_ok  = k4[3];
            dec_k    = 1'b1;
            dec_byte = {k4[2:0], 5'd28};
            comma    = k4[3] && ((k4[2:0] == 3'd1) || (k4[2:0] == 3'd5) || (k4[2:0] == 3'd7));
        end else if (d6[5] && d4[4]) begin
            if (!d4[3]) begin
                code_ok = 1'b1;
            end else if ((d6[4:0] == 5'd23) || (d6[4:0] == 5'd27) ||
                         (d6[4:0] == 5'd29) || (d6[4:0] == 5'd30)) begin
                code_ok = 1'b1;
                dec_k   = 1'b1;
            end else if (four == 4'b0111) begin
                code_ok = (d6[4:0] == 5'd17) || (d6[4:0] == 5'd18) || (d6[4:0] == 5'd20);
            end else begin
                code_ok = (d6[4:0] == 5'd11) || (d6[4:0] == 5'd13) || (d6[4:0] == 5'd14);
            end
        end
    end

    // RD encoding: 1 = positive, 0 = negative. Sub-blocks checked 6b then 4b.
    always_comb begin
        pos6     = ($countones(six) == 4) || (six == 6'b000111);
        neg6     = ($countones(six) == 2) || (six == 6'b111000);
        pos4     = ($countones(four) == 3) || (four == 4'b0011);
        neg4     = ($countones(four) == 1) || (four == 4'b1100);
        rd_mid   = pos6 ? 1'b1 : (neg6 ? 1'b0 : rd_reg);
        rd_next  = pos4 ? 1'b1 : (neg4 ? 1'b0 : rd_mid);
        disp_err = (pos6 && rd_reg) || (neg6 && !rd_reg) ||
                   (pos4 && rd_mid) || (neg4 && !rd_mid);
    end

    logic [7:0] byte_reg;
    logic       k_reg, valid_reg, dec_err_reg, disp_err_reg, comma_reg;

    always_ff @(posedge BitCLK_10 or negedge Reset) begin
        if (!Reset) begin
            byte_reg     <= '0;
            k_reg        <= 1'b0;
            valid_reg    <= 1'b0;
            dec_err_reg  <= 1'b0;
            disp_err_reg <= 1'b0;
            comma_reg    <= 1'b0;
            rd_reg       <= 1'b0;
        end else begin
            valid_reg <= sym_valid_reg;
            if (sym_valid_reg) begin
                byte_reg     <= code_ok ? dec_byte : 8'hFE;
                k_reg        <= code_ok ? dec_k : 1'b1;
                dec_err_reg  <= !code_ok;
                disp_err_reg <= disp_err;
                comma_reg    <= comma;
                rd_reg       <= rd_next;
            end else begin
                dec_err_reg  <= 1'b0;
                disp_err_reg <= 1'b0;
                comma_reg    <= 1'b0;
            end
        end
    end

    state_t        state_reg, state_next;
    logic [CW-1:0] comma_cnt_reg, comma_cnt_next, comma_inc;
    logic [EW-1:0] err_cnt_reg, err_cnt_next, err_inc;
    logic [GW-1:0] good_cnt_reg, good_cnt_next, good_inc;
    logic          synced_reg, synced_next;
    logic          sym_bad, good_comma;

    assign sym_bad    = !code_ok || disp_err;
    assign good_comma = comma && !sym_bad;
    assign comma_inc  = (comma_cnt_reg == {CW{1'b1}}) ? comma_cnt_reg : comma_cnt_reg + 1'b1;
    assign err_inc    = (err_cnt_reg == {EW{1'b1}}) ? err_cnt_reg : err_cnt_reg + 1'b1;
    assign good_inc   = (good_cnt_reg == {GW{1'b1}}) ? good_cnt_reg : good_cnt_reg + 1'b1;

    always_ff @(posedge BitCLK_10 or negedge Reset) begin
        if (!Reset) begin
            state_reg     <= ST_LOS;
            comma_cnt_reg <= '0;
            err_cnt_reg   <= '0;
            good_cnt_reg  <= '0;
            synced_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            comma_cnt_reg <= comma_cnt_next;
            err_cnt_reg   <= err_cnt_next;
            good_cnt_reg  <= good_cnt_next;
            synced_reg    <= synced_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        comma_cnt_next = comma_cnt_reg;
        err_cnt_next   = err_cnt_reg;
        good_cnt_next  = good_cnt_reg;
        if (sym_valid_reg) begin
            case (state_reg)
                ST_LOS: begin
                    if (good_comma) begin
                        if (SYNC_COMMAS <= 1) begin
                            state_next    = ST_SYNC;
                            err_cnt_next  = '0;
                            good_cnt_next = '0;
                        end else begin
                            state_next     = ST_ACQ;
                            comma_cnt_next = CW'(1);
                        end
                    end
                end
                ST_ACQ: begin
                    if (sym_bad) begin
                        state_next     = ST_LOS;
                        comma_cnt_next = '0;
                    end else if (good_comma) begin
                        if (comma_inc >= CW'(SYNC_COMMAS)) begin
                            state_next     = ST_SYNC;
                            comma_cnt_next = '0;
                            err_cnt_next   = '0;
                            good_cnt_next  = '0;
                        end else begin
                            comma_cnt_next = comma_inc;
                        end
                    end
                end
                ST_SYNC: begin
                    if (sym_bad) begin
                        good_cnt_next = '0;
                        if (err_inc >= EW'(ERR_LIMIT)) begin
                            state_next     = ST_LOS;
                            err_cnt_next   = '0;
                            comma_cnt_next = '0;
                        end else begin
                            err_cnt_next = err_inc;
                        end
                    end else if (good_inc >= GW'(GOOD_RUN)) begin
                        good_cnt_next = '0;
                        err_cnt_next  = (err_cnt_reg == '0) ? err_cnt_reg : err_cnt_reg - 1'b1;
                    end else begin
                        good_cnt_next = good_inc;
                    end
                end
                default: state_next = ST_LOS;
            endcase
        end
    end

    always_comb begin
        synced_next = (state_next == ST_SYNC);
    end

    assign rx.RxParallel_8   = byte_reg;
    assign rx.RxDataK        = k_reg;
    assign rx.RxValid_8      = valid_reg;
    assign rx.DecodeError    = dec_err_reg;
    assign rx.DisparityError = disp_err_reg;
    assign rx.CommaDetect    = comma_reg;
    assign rx.Synced         = synced_reg;
endmodule
